// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter: FSM state
//   encodings, grant identifiers, wait counter width and the tie-break helper
//   used when the round-robin option (MEM_ARB_ROUND_ROBIN_EN) is built in.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE    = 2'd0,
        MA_BUSY_IF = 2'd1,
        MA_BUSY_DM = 2'd2
    } ma_state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    localparam int CNT_W = 4;

    // On a tie, the requester that was not granted last time wins.
    function automatic logic tie_winner(input logic last_grant);
        return (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt
//   Load/decrement down-counter that times the wait states of one memory
//   access. Load has priority over decrement; the count saturates at zero.
// Ports
//   clk_i       clock
//   rst_i       synchronous reset, active-high (count -> 0)
//   load_i      load load_val_i this cycle
//   load_val_i  value loaded at the start of an access
//   dec_i       decrement request (ignored when the count is already zero)
//   cnt_o       current count
//   zero_o      count is zero (final cycle of an access)
module mem_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the
//   load/store stage (DM). Each access occupies WAIT_CYCLES+1 cycles with the
//   memory interface held stable; the ack and read data are presented in the
//   final cycle, and a pending requester on the other port is granted in that
//   same cycle so no idle bubble is inserted. stall_o freezes the pipeline
//   while either requester is still waiting.
//
//   Optional build macro MEM_ARB_ROUND_ROBIN_EN: a simultaneous request in
//   IDLE goes to the port not granted last (DM first after reset). Without
//   it DM always wins a tie, since it belongs to the older instruction.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_req_i/if_addr_i      fetch request and address
//   if_rdata_o/if_ack_o     fetched word (0 unless acked), 1-cycle ack
//   dm_req_i/dm_we_i        data request, 1=store 0=load
//   dm_addr_i/dm_wdata_i    data address and store data
//   dm_rdata_o/dm_ack_o     load data (0 unless acked), 1-cycle ack
//   mem_en_o/mem_we_o       memory enable / write enable
//   mem_addr_o/mem_wdata_o  memory address / write data (registered)
//   mem_rdata_i             memory read data, valid in final access cycle
//   stall_o                 pipeline stall, combinational
//
// state      | meaning
// MA_IDLE    | no access in progress, sampling requests
// MA_BUSY_IF | fetch access in progress, cnt counts remaining wait cycles
// MA_BUSY_DM | load/store access in progress, cnt counts remaining wait cycles
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    ma_state_t         state_q, state_d;
    logic              grant_vld;
    logic              grant_sel;
    logic              tie_sel;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GNT_IF;
        end else if (grant_vld) begin
            last_grant_q <= grant_sel;
        end
    end

    assign tie_sel = tie_winner(last_grant_q);
`else
    assign tie_sel = GNT_DM;
`endif

    mem_wait_cnt #(
        .W(CNT_W)
    ) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (grant_vld),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .dec_i      (state_q != MA_IDLE),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_sel = GNT_DM;
        if_ack_o  = 1'b0;
        dm_ack_o  = 1'b0;

        case (state_q)
            MA_IDLE: begin
                if (if_req_i && dm_req_i) begin
                    grant_vld = 1'b1;
                    grant_sel = tie_sel;
                end else if (dm_req_i) begin
                    grant_vld = 1'b1;
                    grant_sel = GNT_DM;
                end else if (if_req_i) begin
                    grant_vld = 1'b1;
                    grant_sel = GNT_IF;
                end
            end
            MA_BUSY_IF: begin
                if (cnt_zero) begin
                    if_ack_o = 1'b1;
                    // Only the other port may be granted here, so an acked
                    // requester that keeps its request high waits for IDLE.
                    if (dm_req_i) begin
                        grant_vld = 1'b1;
                        grant_sel = GNT_DM;
                    end else begin
                        state_d = MA_IDLE;
                    end
                end
            end
            MA_BUSY_DM: begin
                if (cnt_zero) begin
                    dm_ack_o = 1'b1;
                    if (if_req_i) begin
                        grant_vld = 1'b1;
                        grant_sel = GNT_IF;
                    end else begin
                        state_d = MA_IDLE;
                    end
                end
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase

        if (grant_vld) begin
            state_d = (grant_sel == GNT_DM) ? MA_BUSY_DM : MA_BUSY_IF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= MA_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                if (grant_sel == GNT_DM) begin
                    mem_addr_q  <= dm_addr_i;
                    mem_we_q    <= dm_we_i;
                    mem_wdata_q <= dm_wdata_i;
                end else begin
                    mem_addr_q  <= if_addr_i;
                    mem_we_q    <= 1'b0;
                end
            end else if (state_d == MA_IDLE) begin
                // Do not leave a write enable asserted behind a finished store.
                mem_we_q <= 1'b0;
            end
        end
    end

    assign mem_en_o    = (state_q != MA_IDLE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign if_rdata_o = if_ack_o ? mem_rdata_i : '0;
    assign dm_rdata_o = dm_ack_o ? mem_rdata_i : '0;

    assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench: request tasks push the expected ack (data and cycle)
//   into per-port queues; a monitor thread pops and compares on every ack.
//   A second instance with WAIT_CYCLES=0 covers back-to-back fetches.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_init;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        stall_o;

    logic        z_if_req;
    logic [31:0] z_if_addr;
    logic [31:0] z_if_rdata;
    logic        z_if_ack;
    logic        z_dm_req;
    logic        z_dm_we;
    logic [31:0] z_dm_addr;
    logic [31:0] z_dm_wdata;
    logic [31:0] z_dm_rdata;
    logic        z_dm_ack;
    logic        z_mem_en;
    logic        z_mem_we;
    logic [31:0] z_mem_addr;
    logic [31:0] z_mem_wdata;
    logic [31:0] z_mem_rdata;
    logic        z_stall;

    logic [31:0] mem [0:63];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        if_q[$];
    exp_t        dm_q[$];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5A500 | 32'(i);
            mem[4]  <= 32'h8C020004;
            mem[5]  <= 32'h00421820;
            mem[16] <= 32'h11112222;
        end else if (mem_en_o && mem_we_o && dm_ack_o) begin
            mem[mem_addr_o[7:2]] <= mem_wdata_o;
        end
    end

    assign mem_rdata_i = mem_en_o ? mem[mem_addr_o[7:2]] : 32'h0;
    assign z_mem_rdata = z_mem_en ? mem[z_mem_addr[7:2]] : 32'h0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(z_if_req), .if_addr_i(z_if_addr), .if_rdata_o(z_if_rdata), .if_ack_o(z_if_ack),
        .dm_req_i(z_dm_req), .dm_we_i(z_dm_we), .dm_addr_i(z_dm_addr), .dm_wdata_i(z_dm_wdata),
        .dm_rdata_o(z_dm_rdata), .dm_ack_o(z_dm_ack),
        .mem_en_o(z_mem_en), .mem_we_o(z_mem_we), .mem_addr_o(z_mem_addr),
        .mem_wdata_o(z_mem_wdata), .mem_rdata_i(z_mem_rdata), .stall_o(z_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (if_ack_o || dm_ack_o) chk("no_dual_ack", {31'b0, if_ack_o & dm_ack_o}, 32'h0);
            if (if_ack_o) begin
                if (if_q.size() == 0) begin
                    chk("unexpected_if_ack", 32'h1, 32'h0);
                end else begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata_o, e.data);
                    chk("if_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (mem_en_o) begin
                chk("if_rdata_zero", if_rdata_o, 32'h0);
            end
            if (dm_ack_o) begin
                if (dm_q.size() == 0) begin
                    chk("unexpected_dm_ack", 32'h1, 32'h0);
                end else begin
                    e = dm_q.pop_front();
                    if (e.chk_data) chk("dm_rdata", dm_rdata_o, e.data);
                    chk("dm_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (mem_en_o) begin
                chk("dm_rdata_zero", dm_rdata_o, 32'h0);
            end
        end
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after the ack
    // with the request dropped.
    task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_data, input int lat);
        bit got = 0;
        if_req_i  = 1'b1;
        if_addr_i = addr;
        if_q.push_back('{exp_data, 1'b1, cyc + lat});
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_i);
            if (if_ack_o) got = 1;
        end
        if (!got) chk("if_ack_timeout", 32'h0, 32'h1);
        step();
        if_req_i = 1'b0;
    endtask

    task automatic dm_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [31:0] exp_data, input int lat);
        bit got = 0;
        dm_req_i   = 1'b1;
        dm_we_i    = we;
        dm_addr_i  = addr;
        dm_wdata_i = wdata;
        dm_q.push_back('{exp_data, ~we, cyc + lat});
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_i);
            if (dm_ack_o) got = 1;
        end
        if (!got) chk("dm_ack_timeout", 32'h0, 32'h1);
        step();
        dm_req_i = 1'b0;
        dm_we_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; mem_init = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        z_if_req = 1'b0; z_if_addr = '0;
        z_dm_req = 1'b0; z_dm_we = 1'b0; z_dm_addr = '0; z_dm_wdata = '0;

        fork monitor(); join_none

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_en", {31'b0, mem_en_o}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_acks", {30'b0, if_ack_o, dm_ack_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        step();
        rst_i = 1'b0; mem_init = 1'b0;
        step();

        // Single fetch
        fork
            if_access(32'h10, 32'h8C020004, 3);
            begin
                @(negedge clk_i);
                chk("t1_stall_t", {31'b0, stall_o}, 32'h1);
                chk("t1_en_t", {31'b0, mem_en_o}, 32'h0);
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk_i);
                    chk("t1_en", {31'b0, mem_en_o}, 32'h1);
                    chk("t1_we", {31'b0, mem_we_o}, 32'h0);
                    chk("t1_addr", mem_addr_o, 32'h10);
                    chk("t1_stall", {31'b0, stall_o}, (k < 3) ? 32'h1 : 32'h0);
                end
            end
        join
        step();

        // Simultaneous fetch and load: DM first, IF handed over without bubble
        fork
            if_access(32'h14, 32'h00421820, 6);
            dm_access(32'h40, 1'b0, 32'h0, 32'h11112222, 3);
            begin
                for (int k = 0; k <= 6; k++) begin
                    @(negedge clk_i);
                    chk("t2_en", {31'b0, mem_en_o}, (k == 0) ? 32'h0 : 32'h1);
                end
            end
        join
        step();

        // Store, then read back to confirm the commit
        fork
            dm_access(32'h20, 1'b1, 32'hDEADBEEF, 32'h0, 3);
            begin
                @(negedge clk_i);
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk_i);
                    chk("t3_en", {31'b0, mem_en_o}, 32'h1);
                    chk("t3_we", {31'b0, mem_we_o}, 32'h1);
                    chk("t3_addr", mem_addr_o, 32'h20);
                    chk("t3_wdata", mem_wdata_o, 32'hDEADBEEF);
                end
            end
        join
        step();
        dm_access(32'h20, 1'b0, 32'h0, 32'hDEADBEEF, 3);
        step();

        // Reset in the second cycle of a store: access abandoned, no ack
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h24; dm_wdata_i = 32'h12345678;
        step();
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t4_en", {31'b0, mem_en_o}, 32'h0);
        chk("t4_we", {31'b0, mem_we_o}, 32'h0);
        chk("t4_ack", {31'b0, dm_ack_o}, 32'h0);
        chk("t4_addr", mem_addr_o, 32'h0);
        step();
        rst_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        step();
        dm_access(32'h24, 1'b0, 32'h0, 32'hA5A5A509, 3);
        step();

        // WAIT_CYCLES=0: held fetch request is acked every second cycle
        z_if_req = 1'b1; z_if_addr = 32'h10;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk("t5_ack", {31'b0, z_if_ack}, 32'(k % 2));
            chk("t5_stall", {31'b0, z_stall}, 32'((k + 1) % 2));
            if ((k % 2) == 1) chk("t5_rdata", z_if_rdata, 32'h8C020004);
        end
        step();
        z_if_req = 1'b0;
        step();

        // Both ports requesting continuously: grants alternate DM, IF, DM, IF
        fork
            begin
                dm_access(32'h40, 1'b0, 32'h0, 32'h11112222, 3);
                dm_access(32'h44, 1'b0, 32'h0, 32'hA5A5A511, 5);
                dm_access(32'h48, 1'b0, 32'h0, 32'hA5A5A512, 5);
            end
            begin
                if_access(32'h10, 32'h8C020004, 6);
                if_access(32'h14, 32'h00421820, 5);
                if_access(32'h18, 32'hA5A5A506, 5);
            end
        join

        repeat (4) step();
        chk("if_q_drained", 32'(if_q.size()), 32'h0);
        chk("dm_q_drained", 32'(dm_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
